if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch pipeline stage; the upstream end of the fetch-to-decode interface.
- Drives the instruction/PC bus and valid toward decode, and consumes the branch-redirect bus that decode produces.
- Fetches from the instruction SRAM over a req/addr_ok/data_ok handshake.
- Holds at most one request in flight and buffers one fetched instruction.

Parameters:
RESET_PC, 32'h1c000000, first fetch address after reset
FS_TO_DS_BUS_WD, 64, width of fetch-to-decode bus: {inst[31:0], pc[31:0]}
BR_BUS_WD, 33, width of branch bus: {br_taken, br_target[31:0]}

Ports:
clk  input  1  clock; single clock domain
reset  input  1  synchronous, active-high reset
ds_allowin  input  1  decode can accept an instruction this cycle
br_bus  input  BR_BUS_WD  {br_taken, br_target}; br_taken is a level held while a taken branch sits in decode
fs_to_ds_valid  output  1  fs_to_ds_bus holds a valid instruction
fs_to_ds_bus  output  FS_TO_DS_BUS_WD  {inst, pc}
inst_sram_req  output  1  fetch request
inst_sram_addr  output  32  fetch address (word aligned)
inst_sram_addr_ok  input  1  request accepted this cycle
inst_sram_data_ok  input  1  read data valid this cycle
inst_sram_rdata  input  32  read data

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=REQ, pc=RESET_PC, inst_r=0, discard=0, br_taken_d=0.
  - During the reset cycle, outputs are req=0 and fs_to_ds_valid=0.
  - fs_to_ds_bus={32'h0, RESET_PC}.
  - The first request is issued in the cycle after reset deasserts.
- Redirect event: redir = br_taken & ~br_taken_d. br_taken_d registers br_taken every cycle.
  - Edge detection makes a held br_taken act exactly once.
  - Decode always presents at least one non-taken cycle between branches, because fs_to_ds_valid is suppressed behind each branch.
  - On redir: pc <= br_target.
- fs_to_ds_valid = (state==HOLD) & ~br_taken. The wrong-path instruction is never handed over while a branch sits in decode.
- Handoff occurs when fs_to_ds_valid & ds_allowin.
- fs_to_ds_bus = {inst_r, pc}. It stays stable while valid and not handed off.
- inst_sram_req = (state==REQ) & ~reset. inst_sram_addr = pc.
- States and transitions:
  - REQ:
    - addr_ok=1 -> WAIT. If redir in the same cycle, the old address is already accepted, so set discard=1.
    - redir without addr_ok: stay REQ. The address becomes the target next cycle; the req line stays high.
  - WAIT:
    - data_ok & (discard | redir): drop data, clear discard -> REQ.
    - data_ok otherwise: inst_r <= rdata -> HOLD.
    - redir without data_ok: discard <= 1, stay WAIT.
  - HOLD:
    - redir: drop inst_r -> REQ at target.
    - handoff: pc <= pc+4 -> REQ.
    - else: stay HOLD.
- pc+4 wraps modulo 2^32.
- Throughput: at most one instruction every 3 cycles (REQ, WAIT, HOLD). Minimum latency from request to fs_to_ds_valid is 2 cycles after addr_ok with data_ok the next cycle.
- Discarded responses never update inst_r and never assert fs_to_ds_valid.
- Reset mid-operation:
  - Any outstanding response arriving after reset is ignored, because state is REQ.
  - The slave is required to drop in-flight transactions on reset.

Test Plan:
- Reset, then addr_ok=1 and data_ok=1 one cycle after each request, ds_allowin=1 -> addr sequence 1c000000, 1c000004, 1c000008. Each bus pairs the matching rdata and pc. Valid is high for 1 cycle per fetch.
- ds_allowin=0 for 5 cycles in HOLD -> valid stays 1 and bus is stable. No new req until handoff; the next addr is pc+4.
- br_taken=1 (target 1c000100) held 3 cycles while in HOLD -> valid=0 throughout. The buffered instruction is never handed off; the next req addr is 1c000100.
- br_taken rises in WAIT; data_ok arrives 2 cycles later -> data discarded, no valid. The next req addr is the target.
- br_taken rises in the same cycle as addr_ok in REQ -> the response to the old address is discarded. Exactly one subsequent request goes to the target.
- pc=32'hfffffffc handoff -> next req addr 32'h00000000.
- reset asserted while in WAIT, data_ok arrives next cycle -> ignored. req reissues at 1c000000.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues one SRAM fetch at a time over a req/addr_ok/data_ok
// handshake, buffers the returned instruction and hands it to decode, honouring redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          FS_TO_DS_BUS_WD = 64,
  parameter int          BR_BUS_WD       = 33
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_req,
  output logic [31:0]                inst_sram_addr,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        discard_q, discard_d;
  logic        br_taken_q;

  logic        br_taken_s;
  logic [31:0] br_target_s;
  logic        redir_s;
  logic        handoff_s;

  assign br_taken_s  = br_bus[32];
  assign br_target_s = br_bus[31:0];
  // A held br_taken level redirects only on its first cycle.
  assign redir_s     = br_taken_s & ~br_taken_q;

  assign fs_to_ds_valid = (state_q == S_HOLD) & ~br_taken_s;
  assign handoff_s      = fs_to_ds_valid & ds_allowin;
  assign fs_to_ds_bus   = {inst_q, pc_q};
  assign inst_sram_req  = (state_q == S_REQ) & ~reset;
  assign inst_sram_addr = pc_q;

  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    discard_d = discard_q;
    if (redir_s) begin
      pc_d = br_target_s;
    end else if (handoff_s) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end

    case (state_q)
      S_REQ: begin
        // Redirect while the old address is accepted: its response must be dropped.
        if (inst_sram_addr_ok) begin
          state_d   = S_WAIT;
          discard_d = redir_s;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          if (discard_q | redir_s) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            inst_d  = inst_sram_rdata;
            state_d = S_HOLD;
          end
        end else if (redir_s) begin
          discard_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (redir_s | handoff_s) begin
          state_d = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d   = S_REQ;
        discard_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      inst_q     <= 32'h0;
      discard_q  <= 1'b0;
      br_taken_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      discard_q  <= discard_d;
      br_taken_q <= br_taken_s;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, decode stall, redirects in each state,
// pc wrap-around and reset with a response in flight.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  int vectors = 0;
  int miscompares = 0;

  if_stage dut (
    .clk              (clk),
    .reset            (reset),
    .ds_allowin       (ds_allowin),
    .br_bus           (br_bus),
    .fs_to_ds_valid   (fs_to_ds_valid),
    .fs_to_ds_bus     (fs_to_ds_bus),
    .inst_sram_req    (inst_sram_req),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata  (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1-2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ds_allowin = 1'b0; br_bus = 33'h0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
    tick(); tick();
    #1;
    vectors++;
    if (inst_sram_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b want 0", inst_sram_req); end
    vectors++;
    if (fs_to_ds_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", fs_to_ds_valid); end
    vectors++;
    if (fs_to_ds_bus !== {32'h0, 32'h1c000000}) begin miscompares++; $display("FAIL rst_bus got %h want %h", fs_to_ds_bus, {32'h0, 32'h1c000000}); end
    reset = 1'b0;
    #1;
    vectors++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000000) begin
      miscompares++; $display("FAIL rst_first_req got %b/%h want 1/1c000000", inst_sram_req, inst_sram_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    logic [31:0] data;
    ds_allowin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h1c000000 + 32'(i) * 32'd4;
      data   = 32'ha0000000 + 32'(i);
      #1;
      vectors++;
      if (inst_sram_req !== 1'b1 || inst_sram_addr !== exp_pc || fs_to_ds_valid !== 1'b0) begin
        miscompares++; $display("FAIL seq_req%0d got %b/%h/%b want 1/%h/0", i, inst_sram_req, inst_sram_addr, fs_to_ds_valid, exp_pc);
      end
      inst_sram_addr_ok = 1'b1;
      tick();
      inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = data;
      #1;
      vectors++;
      if (inst_sram_req !== 1'b0 || fs_to_ds_valid !== 1'b0) begin
        miscompares++; $display("FAIL seq_wait%0d got req=%b valid=%b want 0/0", i, inst_sram_req, fs_to_ds_valid);
      end
      tick();
      inst_sram_data_ok = 1'b0;
      #1;
      vectors++;
      if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {data, exp_pc}) begin
        miscompares++; $display("FAIL seq_hold%0d got %b/%h want 1/%h", i, fs_to_ds_valid, fs_to_ds_bus, {data, exp_pc});
      end
      tick();
    end
  endtask

  task automatic test_stall();
    ds_allowin = 1'b0;
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h11111111;
    tick();
    inst_sram_data_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (fs_to_ds_valid !== 1'b1 || inst_sram_req !== 1'b0 || fs_to_ds_bus !== {32'h11111111, 32'h1c00000c}) begin
        miscompares++; $display("FAIL stall%0d got v=%b req=%b bus=%h", i, fs_to_ds_valid, inst_sram_req, fs_to_ds_bus);
      end
      tick();
    end
    ds_allowin = 1'b1;
    tick();
    #1;
    vectors++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000010 || fs_to_ds_valid !== 1'b0) begin
      miscompares++; $display("FAIL stall_next got %b/%h/%b want 1/1c000010/0", inst_sram_req, inst_sram_addr, fs_to_ds_valid);
    end
  endtask

  task automatic test_branch_hold();
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h22222222;
    tick();
    inst_sram_data_ok = 1'b0;
    br_bus = {1'b1, 32'h1c000100};
    #1;
    vectors++;
    if (fs_to_ds_valid !== 1'b0) begin miscompares++; $display("FAIL brhold_c0 valid got %b want 0", fs_to_ds_valid); end
    tick();
    for (int i = 1; i < 3; i++) begin
      #1;
      vectors++;
      if (fs_to_ds_valid !== 1'b0 || inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000100) begin
        miscompares++; $display("FAIL brhold_c%0d got %b/%b/%h want 0/1/1c000100", i, fs_to_ds_valid, inst_sram_req, inst_sram_addr);
      end
      tick();
    end
    br_bus = 33'h0;
    #1;
    vectors++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000100) begin
      miscompares++; $display("FAIL brhold_after got %b/%h want 1/1c000100", inst_sram_req, inst_sram_addr);
    end
  endtask

  task automatic test_branch_wait();
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    br_bus = {1'b1, 32'h1c000200};
    tick();
    #1;
    vectors++;
    if (fs_to_ds_valid !== 1'b0 || inst_sram_req !== 1'b0) begin
      miscompares++; $display("FAIL brwait_t1 got v=%b req=%b want 0/0", fs_to_ds_valid, inst_sram_req);
    end
    tick();
    br_bus = 33'h0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hdeadbeef;
    tick();
    inst_sram_data_ok = 1'b0;
    #1;
    vectors++;
    if (fs_to_ds_valid !== 1'b0 || inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000200) begin
      miscompares++; $display("FAIL brwait_drop got %b/%b/%h want 0/1/1c000200", fs_to_ds_valid, inst_sram_req, inst_sram_addr);
    end
  endtask

  task automatic test_branch_addr_ok();
    inst_sram_addr_ok = 1'b1;
    br_bus = {1'b1, 32'h1c000300};
    tick();
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hbadbad00;
    tick();
    inst_sram_data_ok = 1'b0; br_bus = 33'h0;
    #1;
    vectors++;
    if (fs_to_ds_valid !== 1'b0 || inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000300) begin
      miscompares++; $display("FAIL braok_drop got %b/%b/%h want 0/1/1c000300", fs_to_ds_valid, inst_sram_req, inst_sram_addr);
    end
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h33333333;
    tick();
    inst_sram_data_ok = 1'b0;
    #1;
    vectors++;
    if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {32'h33333333, 32'h1c000300}) begin
      miscompares++; $display("FAIL braok_hold got %b/%h want 1/%h", fs_to_ds_valid, fs_to_ds_bus, {32'h33333333, 32'h1c000300});
    end
    tick();
    #1;
    vectors++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000304) begin
      miscompares++; $display("FAIL braok_next got %b/%h want 1/1c000304", inst_sram_req, inst_sram_addr);
    end
  endtask

  task automatic test_wrap();
    br_bus = {1'b1, 32'hfffffffc};
    tick();
    br_bus = 33'h0;
    #1;
    vectors++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'hfffffffc) begin
      miscompares++; $display("FAIL wrap_redir got %b/%h want 1/fffffffc", inst_sram_req, inst_sram_addr);
    end
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h44444444;
    tick();
    inst_sram_data_ok = 1'b0;
    #1;
    vectors++;
    if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {32'h44444444, 32'hfffffffc}) begin
      miscompares++; $display("FAIL wrap_hold got %b/%h want 1/%h", fs_to_ds_valid, fs_to_ds_bus, {32'h44444444, 32'hfffffffc});
    end
    tick();
    #1;
    vectors++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h00000000) begin
      miscompares++; $display("FAIL wrap_next got %b/%h want 1/00000000", inst_sram_req, inst_sram_addr);
    end
  endtask

  task automatic test_reset_mid();
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    reset = 1'b1;
    tick();
    #1;
    vectors++;
    if (inst_sram_req !== 1'b0 || fs_to_ds_valid !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_in got req=%b v=%b want 0/0", inst_sram_req, fs_to_ds_valid);
    end
    reset = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h55555555;
    #1;
    vectors++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000000) begin
      miscompares++; $display("FAIL rstmid_req got %b/%h want 1/1c000000", inst_sram_req, inst_sram_addr);
    end
    tick();
    inst_sram_data_ok = 1'b0;
    #1;
    vectors++;
    if (fs_to_ds_valid !== 1'b0 || inst_sram_req !== 1'b1 || fs_to_ds_bus !== {32'h0, 32'h1c000000}) begin
      miscompares++; $display("FAIL rstmid_ignore got v=%b req=%b bus=%h", fs_to_ds_valid, inst_sram_req, fs_to_ds_bus);
    end
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'h66666666;
    tick();
    inst_sram_data_ok = 1'b0;
    #1;
    vectors++;
    if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {32'h66666666, 32'h1c000000}) begin
      miscompares++; $display("FAIL rstmid_fetch got %b/%h want 1/%h", fs_to_ds_valid, fs_to_ds_bus, {32'h66666666, 32'h1c000000});
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_hold();
    test_branch_wait();
    test_branch_addr_ok();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
